// File: rtl/riscv_pkg.sv
// Shared types for the branch resolution slice.
// Holds the shadow-pipeline record carried from fetch to execute.
package riscv_pkg;

    localparam int XLEN_W = 32;
    localparam logic [XLEN_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic              valid;
        logic [XLEN_W-1:0] pc;
        logic              pred;
    } br_rec_t;

endpackage

// File: rtl/br_stage_reg.sv
// One shadow-pipeline record register.
// A kill wins over hold so a flush clears records even while stalled.
module br_stage_reg
    import riscv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    hold,
    input  logic    kill,
    input  br_rec_t d,
    output br_rec_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (kill) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Tracks predictions to execute, resolves branches, and drives
// predictor training, fetch redirect/flush and performance counters.
module branch_resolve
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [XLEN-1:0]  f_pc,
    input  logic             f_pred,
    input  logic             stall,
    input  logic             e_is_branch,
    input  logic             e_taken,
    input  logic [XLEN-1:0]  e_target,
    output logic             is_branch_prev,
    output logic             branch_taken,
    output logic [XLEN-1:0]  epc,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    br_rec_t f_rec;
    br_rec_t d_q;
    br_rec_t e_q;

    logic            res;
    logic            mis;
    logic [XLEN-1:0] nxt_pc;

    // Fetch is on the wrong path while a flush is being signalled.
    always_comb begin
        f_rec       = '0;
        f_rec.valid = f_valid & ~flush;
        f_rec.pc    = f_pc;
        f_rec.pred  = f_pred;
    end

    br_stage_reg u_d_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .kill (mis),
        .d    (f_rec),
        .q    (d_q)
    );

    br_stage_reg u_e_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .kill (mis),
        .d    (d_q),
        .q    (e_q)
    );

    assign res    = e_q.valid & e_is_branch & ~stall;
    assign mis    = res & (e_taken != e_q.pred);
    assign nxt_pc = e_taken ? e_target : e_q.pc + PC_INC;
    assign flush  = redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_branch_prev <= 1'b0;
            branch_taken   <= 1'b0;
            redirect       <= 1'b0;
            epc            <= '0;
            redirect_pc    <= '0;
        end else begin
            is_branch_prev <= res;
            branch_taken   <= res & e_taken;
            redirect       <= mis;
            if (res) begin
                epc         <= e_q.pc;
                redirect_pc <= nxt_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (res && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mis && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolution-side counterpart to the local-history branch predictor. It carries each fetched instruction's prediction bit alongside the pipeline from fetch through decode to execute, where it compares the prediction with the ALU's actual outcome. It then returns the registered training update (`is_branch_prev`, `branch_taken`, `epc`) to the predictor, and drives the redirect and flush that recover fetch after a misprediction. It also keeps saturating branch and mispredict counters for performance readout.

## Interface
- `XLEN`, 32, PC and target width
- `CNT_W`, 32, statistics counter width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `f_valid`  in  1  instruction leaving fetch this cycle
- `f_pc`  in  XLEN  its PC
- `f_pred`  in  1  predictor output for `f_pc` (1 = taken)
- `stall`  in  1  pipeline hold; no stage advances
- `e_is_branch`  in  1  instruction in execute is a conditional branch
- `e_taken`  in  1  actual branch outcome from ALU
- `e_target`  in  XLEN  computed branch target
- `is_branch_prev`  out  1  predictor update strobe
- `branch_taken`  out  1  resolved outcome for the update
- `epc`  out  XLEN  PC of the resolved branch
- `redirect`  out  1  fetch must restart at `redirect_pc`
- `redirect_pc`  out  XLEN  correct next PC
- `flush`  out  1  kill fetch/decode contents (equal to `redirect`)
- `br_count`  out  CNT_W  branches resolved
- `mispred_count`  out  CNT_W  mispredictions

## Operation
- Shadow pipeline: two records, D and E, each `{valid, pc, pred}`.
- When `!stall`, records shift on each clock: D ← `{f_valid, f_pc, f_pred}` and E ← D.
- When `stall` is high, both records hold.
- Resolve condition `res` = `E.valid & e_is_branch & !stall`. A branch is evaluated exactly once, on the cycle it leaves execute.
- `mis` = `res & (e_taken != E.pred)`.
- Registered outputs on the clock after `res`:
  - `is_branch_prev` = 1, `branch_taken` = `e_taken`, `epc` = `E.pc`.
  - `redirect` = `flush` = `mis`.
  - `redirect_pc` = `e_taken ? e_target : E.pc + 4`, computed modulo 2^XLEN so it wraps at the top of the address space.
- On the clock where `mis` is sampled, D.valid and E.valid clear, overriding the shift. The younger instructions were fetched down the wrong path.
- While `flush` is high, the fetch input is ignored: D loads `valid` = 0.
- `br_count` increments on `res`. `mispred_count` increments on `mis`. Both saturate at all-ones.
- A non-branch in E, or an invalid E, produces no update and no redirect.

## Timing
- Reset (`rst` sampled high):
  - D and E invalid.
  - `is_branch_prev`, `branch_taken`, `redirect`, `flush` = 0.
  - `epc`, `redirect_pc` = 0.
  - Both counters = 0.
- Reset takes precedence over every other event, including a pending resolve.
- Latency from execute to update/redirect: 1 cycle, all outputs registered.
- The update lands one cycle after execute, which matches the predictor's previous-branch training port.
- Update and redirect outputs are 1-cycle pulses. They are not held across `stall`.
- `stall` coincident with a branch in E: no resolve, no pulse. The branch resolves on the first non-stalled cycle.
- `mis` with `stall` asserted in the following cycle: the flush still fires, and records stay cleared.
- A branch entering E on the cycle after a flush is impossible, because D was cleared. Back-to-back resolves on consecutive unstalled cycles are legal and each produces its own pulse.

## Structure
- Shared package `riscv_pkg`:
  - `br_rec_t` struct `{logic valid; logic [XLEN-1:0] pc; logic pred;}`.
  - Constant `PC_INC` = 4.
- Sub-module `br_stage_reg`: one `br_rec_t` register with `rst`, `hold`, `kill` and `d` inputs. Priority is `rst` > `kill` > `hold`. Instantiate it twice, once for D and once for E.
- The counters are inline saturating incrementers.

## Test plan
- Reset then idle: all outputs 0 after `rst`; 10 idle cycles produce no pulses and counters stay 0.
- Correct prediction: fetch `f_pc`=0x100 with `f_pred`=1; two cycles later `e_is_branch`=1, `e_taken`=1. Next cycle: `is_branch_prev`=1, `branch_taken`=1, `epc`=0x100, `redirect`=0, `br_count`=1.
- Mispredict not-taken→taken: `f_pc`=0x200, `f_pred`=0, `e_taken`=1, `e_target`=0x80. Required:
  - Next cycle: `redirect`=`flush`=1, `redirect_pc`=0x80, `mispred_count`=1.
  - The younger instruction in D produces no update.
- Mispredict taken→not-taken at top of space: `f_pc`=0xFFFFFFFC, `f_pred`=1, `e_taken`=0 → `redirect_pc`=0x00000000.
- Stall hold: branch in E with `stall` high for 3 cycles → no pulse during stall; exactly one update on the cycle after `stall` drops; `br_count` advances by 1.
- Saturation and reset mid-flight: with `CNT_W`=2, resolve 5 mispredicts → both counters read 3. Asserting `rst` on the cycle a branch resolves → no pulse next cycle, counters 0.
